// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Owner tag carried alongside each in-flight read.
  typedef enum logic {
    TAG_A = 1'b0,
    TAG_B = 1'b1
  } tag_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; grant is combinational, pointer moves to the
// loser after every accepted grant so a held request waits at most one command.
module rr_arbiter_2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  tag_t ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr == TAG_A) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= TAG_A;
    end else if (advance && (gnt != 2'b00)) begin
      ptr <= gnt[0] ? TAG_B : TAG_A;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a registered-read single-port memory between requesters A and B.
// Optional post-reset clear sweep; read data returns 3 cycles after acceptance.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_ReqA,
  input  logic                  i_ReqB,
  input  logic                  i_WeA,
  input  logic                  i_WeB,
  input  logic [ADDR_WIDTH-1:0] i_AddrA,
  input  logic [ADDR_WIDTH-1:0] i_AddrB,
  input  logic [DATA_WIDTH-1:0] i_DataA,
  input  logic [DATA_WIDTH-1:0] i_DataB,
  output logic                  o_GntA,
  output logic                  o_GntB,
  output logic                  o_RdValidA,
  output logic                  o_RdValidB,
  output logic [DATA_WIDTH-1:0] o_RdDataA,
  output logic [DATA_WIDTH-1:0] o_RdDataB,
  output logic                  o_MemWriteEnable,
  output logic [ADDR_WIDTH-1:0] o_MemAddress,
  output logic [DATA_WIDTH-1:0] o_MemDataIn,
  input  logic [DATA_WIDTH-1:0] i_MemDataOut,
  output logic                  o_Ready
);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clearing;
  logic                  ready;
  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [1:0]            tag_vld;
  logic [1:0]            tag_own;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if ((state == ST_CLEAR) && (&clr_cnt)) begin
      state_nxt = ST_RUN;
    end
  end

  // Ready is masked by reset so nothing is granted while reset is held.
  always_comb begin
    clearing = (state == ST_CLEAR);
    ready    = (state == ST_RUN) && !i_Reset;
  end

  assign req     = ready ? {i_ReqB, i_ReqA} : 2'b00;
  assign o_GntA  = gnt[0];
  assign o_GntB  = gnt[1];
  assign o_Ready = ready;

  rr_arbiter_2 u_arb (
    .clk     (i_Clock),
    .rst     (i_Reset),
    .req     (req),
    .advance (ready),
    .gnt     (gnt)
  );

  always_comb begin
    sel_we   = i_WeA;
    sel_addr = i_AddrA;
    sel_data = i_DataA;
    if (gnt[1]) begin
      sel_we   = i_WeB;
      sel_addr = i_AddrB;
      sel_data = i_DataB;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      clr_cnt <= '0;
    end else if (clearing) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Idle cycles drop write enable but keep the last address and data on the bus.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_MemWriteEnable <= 1'b0;
      o_MemAddress     <= '0;
      o_MemDataIn      <= '0;
    end else if (clearing) begin
      o_MemWriteEnable <= 1'b1;
      o_MemAddress     <= clr_cnt;
      o_MemDataIn      <= CLEAR_VALUE;
    end else if (gnt != 2'b00) begin
      o_MemWriteEnable <= sel_we;
      o_MemAddress     <= sel_addr;
      o_MemDataIn      <= sel_data;
    end else begin
      o_MemWriteEnable <= 1'b0;
    end
  end

  // Stage 0 covers the command register cycle, stage 1 the memory read cycle.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tag_vld <= 2'b00;
      tag_own <= 2'b00;
    end else begin
      tag_vld <= {tag_vld[0], (gnt != 2'b00) && !sel_we};
      tag_own <= {tag_own[0], gnt[1]};
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_RdValidA <= 1'b0;
      o_RdValidB <= 1'b0;
      o_RdDataA  <= '0;
      o_RdDataB  <= '0;
    end else begin
      o_RdValidA <= tag_vld[1] && (tag_own[1] == TAG_A);
      o_RdValidB <= tag_vld[1] && (tag_own[1] == TAG_B);
      if (tag_vld[1] && (tag_own[1] == TAG_A)) begin
        o_RdDataA <= i_MemDataOut;
      end
      if (tag_vld[1] && (tag_own[1] == TAG_B)) begin
        o_RdDataB <= i_MemDataOut;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with a behavioural 16x4 registered-read memory.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [3:0] addr_a = '0, data_a = '0, addr_b = '0, data_b = '0;
  logic       gnt_a, gnt_b, rd_valid_a, rd_valid_b, mem_we, ready;
  logic [3:0] rd_data_a, rd_data_b, mem_addr, mem_din;
  logic [3:0] mem_dout;
  logic [3:0] mem [16];

  logic       req0 = 1'b1;
  logic       d0_gnt_a, d0_gnt_b, d0_rv_a, d0_rv_b, d0_we, d0_ready;
  logic [3:0] d0_rd_a, d0_rd_b, d0_addr, d0_din;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .i_Clock(clk), .i_Reset(rst),
    .i_ReqA(req_a), .i_ReqB(req_b), .i_WeA(we_a), .i_WeB(we_b),
    .i_AddrA(addr_a), .i_AddrB(addr_b), .i_DataA(data_a), .i_DataB(data_b),
    .o_GntA(gnt_a), .o_GntB(gnt_b), .o_RdValidA(rd_valid_a), .o_RdValidB(rd_valid_b),
    .o_RdDataA(rd_data_a), .o_RdDataB(rd_data_b),
    .o_MemWriteEnable(mem_we), .o_MemAddress(mem_addr), .o_MemDataIn(mem_din),
    .i_MemDataOut(mem_dout), .o_Ready(ready)
  );

  mem_port_arbiter #(.CLEAR_ON_RESET(1'b0)) dut0 (
    .i_Clock(clk), .i_Reset(rst),
    .i_ReqA(req0), .i_ReqB(1'b0), .i_WeA(1'b0), .i_WeB(1'b0),
    .i_AddrA(4'h0), .i_AddrB(4'h0), .i_DataA(4'h0), .i_DataB(4'h0),
    .o_GntA(d0_gnt_a), .o_GntB(d0_gnt_b), .o_RdValidA(d0_rv_a), .o_RdValidB(d0_rv_b),
    .o_RdDataA(d0_rd_a), .o_RdDataB(d0_rd_b),
    .o_MemWriteEnable(d0_we), .o_MemAddress(d0_addr), .o_MemDataIn(d0_din),
    .i_MemDataOut(4'h0), .o_Ready(d0_ready)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  typedef struct {
    logic       own;
    logic [3:0] dat;
    int         at;
  } rd_exp_t;

  rd_exp_t    sb[$];
  rd_exp_t    e;
  logic [3:0] shadow [16];
  logic       ptr_b = 1'b0;
  logic       bus_known = 1'b0;
  logic       exp_we = 1'b0;
  logic [3:0] exp_addr = '0, exp_din = '0;
  int         cyc = 0;
  int         n_checks = 0, n_errors = 0;
  int         rv_a_cnt = 0, rv_b_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid_a === 1'b1) rv_a_cnt++;
    if (rd_valid_b === 1'b1) rv_b_cnt++;
    if (rd_valid_a === 1'b1 || rd_valid_b === 1'b1) begin
      check("rd_both", {31'd0, rd_valid_a && rd_valid_b}, 0);
      if (sb.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rd_owner", {31'd0, rd_valid_b}, {31'd0, e.own});
        check("rd_data", {28'd0, rd_valid_b ? rd_data_b : rd_data_a}, {28'd0, e.dat});
        check("rd_cycle", cyc, e.at);
      end
    end
  end

  task automatic accept(input logic own, input logic we, input logic [3:0] a, input logic [3:0] d);
    if (we) shadow[a] = d;
    else sb.push_back('{own, shadow[a], cyc + 3});
    ptr_b     = ~own;
    exp_we    = we;
    exp_addr  = a;
    exp_din   = d;
    bus_known = 1'b1;
  endtask

  task automatic step(input logic ra, input logic wa, input logic [3:0] aa, input logic [3:0] da,
                      input logic rb, input logic wb, input logic [3:0] ab, input logic [3:0] db,
                      output logic ga, output logic gb);
    req_a = ra; we_a = wa; addr_a = aa; data_a = da;
    req_b = rb; we_b = wb; addr_b = ab; data_b = db;
    @(negedge clk);
    ga = ra && (!rb || !ptr_b);
    gb = rb && !ga;
    check("ready", {31'd0, ready}, 1);
    check("gnt_a", {31'd0, gnt_a}, {31'd0, ga});
    check("gnt_b", {31'd0, gnt_b}, {31'd0, gb});
    if (bus_known) begin
      check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      check("mem_addr", {28'd0, mem_addr}, {28'd0, exp_addr});
      if (exp_we) check("mem_din", {28'd0, mem_din}, {28'd0, exp_din});
    end
    if (ga) accept(1'b0, wa, aa, da);
    else if (gb) accept(1'b1, wb, ab, db);
    else exp_we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic ga, gb;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
  endtask

  // Reset, then walk the sweep cycle by cycle with a read held on port A.
  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    bus_known = 1'b0;
    ptr_b = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = 4'h0;
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'h5; data_a = 4'h0;
    req_b = 1'b0; we_b = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 0);
    check("rst_gnt", {30'd0, gnt_a, gnt_b}, 0);
    check("rst_we", {31'd0, mem_we}, 0);
    check("rst_addr", {28'd0, mem_addr}, 0);
    check("rst_rdvalid", {30'd0, rd_valid_a, rd_valid_b}, 0);
    check("rst_ready0", {31'd0, d0_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      check("clr_ready", {31'd0, ready}, (i == 17) ? 1 : 0);
      check("clr_gnt_a", {31'd0, gnt_a}, (i == 17) ? 1 : 0);
      check("clr_we", {31'd0, mem_we}, (i >= 2) ? 1 : 0);
      check("clr_addr", {28'd0, mem_addr}, (i >= 2) ? i - 2 : 0);
      if (i >= 2) check("clr_din", {28'd0, mem_din}, 0);
      if (i == 1) begin
        check("nc_ready", {31'd0, d0_ready}, 1);
        check("nc_gnt", {31'd0, d0_gnt_a}, 1);
      end
      if (i == 17) accept(1'b0, 1'b0, 4'h5, 4'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic ga, gb, prev_ga;
    int   a_idx, b_idx, rva0, rvb0;

    do_reset();
    idle(4);

    // Write then read of the same address from the other port.
    rva0 = rv_a_cnt; rvb0 = rv_b_cnt;
    step(1, 1, 4'h3, 4'hA, 0, 0, 0, 0, ga, gb);
    step(0, 0, 0, 0, 1, 0, 4'h3, 4'h0, ga, gb);
    idle(5);
    check("wr_rd_a_quiet", rv_a_cnt - rva0, 0);
    check("wr_rd_b_count", rv_b_cnt - rvb0, 1);

    for (int i = 0; i < 16; i++) begin
      logic [3:0] d;
      d = 4'((i * 7 + 3) & 15);
      step(1, 1, 4'(i), d, 0, 0, 0, 0, ga, gb);
    end
    idle(2);

    // Both ports hold reads; grants must alternate.
    a_idx = 0; b_idx = 0; prev_ga = 1'b0;
    rva0 = rv_a_cnt; rvb0 = rv_b_cnt;
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 4'(a_idx), 0, 1, 0, 4'(8 + b_idx), 0, ga, gb);
      if (k > 0) check("alternate", {31'd0, ga}, {31'd0, ~prev_ga});
      prev_ga = ga;
      if (ga) a_idx++;
      if (gb) b_idx++;
    end
    idle(5);
    check("both_a_pulses", rv_a_cnt - rva0, 4);
    check("both_b_pulses", rv_b_cnt - rvb0, 4);

    // Port A alone streams 16 reads.
    rva0 = rv_a_cnt;
    for (int i = 0; i < 16; i++) step(1, 0, 4'(i), 0, 0, 0, 0, 0, ga, gb);
    idle(5);
    check("stream_a_pulses", rv_a_cnt - rva0, 16);

    // Reset with two reads in flight; nothing may return and memory is re-cleared.
    step(1, 0, 4'h2, 0, 0, 0, 0, 0, ga, gb);
    step(0, 0, 0, 0, 1, 0, 4'h9, 0, ga, gb);
    rva0 = rv_a_cnt; rvb0 = rv_b_cnt;
    do_reset();
    check("flush_pulses", (rv_a_cnt - rva0) + (rv_b_cnt - rvb0), 0);
    for (int i = 0; i < 16; i++) step(1, 0, 4'(i), 0, 0, 0, 0, 0, ga, gb);
    idle(5);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
